ex_muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the EX stage, implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the single-cycle ALU and accepts operands from the ID/EX register (Read_data1, Read_data2). While an operation runs it holds the pipeline with a stall. It then presents a 32-bit result for one cycle, and the EX/MEM mux selects that result instead of ALU_result.

---
 rtl/ex_muldiv_seq.sv | 150 +++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// ============================================================================
// Module   : ex_muldiv_seq
// Purpose  : Iterative RV32M multiply/divide sequencer for the EX stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [2:0]        op;
   logic              neg;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opb;
   logic [XLEN-1:0]   rem;

   // Operand decode at acceptance
   logic            is_div, sgn1_en, sgn2_en, s1, s2, div_zero, div_ovf;
   logic [XLEN-1:0] abs1, abs2, special_res;

   assign is_div   = funct3[2];
   assign sgn1_en  = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
   assign sgn2_en  = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
   assign s1       = sgn1_en & src1[XLEN-1];
   assign s2       = sgn2_en & src2[XLEN-1];
   assign abs1     = s1 ? ('0 - src1) : src1;
   assign abs2     = s2 ? ('0 - src2) : src2;
   assign div_zero = is_div & (src2 == '0);
   assign div_ovf  = ((funct3 == 3'b100) | (funct3 == 3'b110)) &
                     (src1 == {1'b1, {(XLEN-1){1'b0}}}) & (src2 == '1);
   // Divide-by-zero wins; overflow gives the dividend as quotient, zero as remainder
   assign special_res = div_zero ? (funct3[1] ? src1 : '1) : (funct3[1] ? '0 : src1);

   // One iteration of shift-add multiply and restoring divide
   logic [XLEN:0]     mul_sum, div_trial, div_diff;
   logic [2*XLEN-1:0] mul_next, acc_step;
   logic [XLEN-1:0]   rem_next, quo_next;
   logic              div_ge, unused_diff_msb;

   assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
   assign mul_next  = {mul_sum, acc[XLEN-1:1]};
   assign div_trial = {rem, acc[XLEN-1]};
   assign div_diff  = div_trial - {1'b0, opb};
   assign div_ge    = div_trial >= {1'b0, opb};
   assign rem_next  = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
   assign quo_next  = {acc[XLEN-2:0], div_ge};
   assign acc_step  = op[2] ? {acc[2*XLEN-1:XLEN], quo_next} : mul_next;
   assign unused_diff_msb = div_diff[XLEN];

   // Sign correction applied to the values produced by the final iteration
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

   assign prod_fix = neg ? ('0 - mul_next) : mul_next;
   assign quo_fix  = neg ? ('0 - quo_next) : quo_next;
   assign rem_fix  = neg ? ('0 - rem_next) : rem_next;

   always_comb begin
      final_res = rem_fix;
      case (op)
         3'b000:                 final_res = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         final_res = quo_fix;
         default:                final_res = rem_fix;
      endcase
   end

   assign stall = ((state == S_IDLE) & start & ~flush) | (state == S_CALC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         op     <= '0;
         neg    <= 1'b0;
         acc    <= '0;
         opb    <= '0;
         rem    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else if (flush) begin
         state <= S_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op  <= funct3;
                  neg <= (funct3 == 3'b110) ? s1 : (s1 ^ s2);
                  cnt <= '0;
                  rem <= '0;
                  acc <= is_div ? {{XLEN{1'b0}}, abs1} : {{XLEN{1'b0}}, abs2};
                  opb <= is_div ? abs2 : abs1;
                  if (div_zero | div_ovf) begin
                     result <= special_res;
                     done   <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     busy  <= 1'b1;
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               acc <= acc_step;
               rem <= rem_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(XLEN-1)) begin
                  result <= final_res;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_seq.sv
// ============================================================================
// Module   : tb_ex_muldiv_seq
// Purpose  : Directed self-checking bench for ex_muldiv_seq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        stall, busy, done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   ex_muldiv_seq #(.XLEN(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .funct3 (funct3),
      .src1   (src1),
      .src2   (src2),
      .flush  (flush),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one operation, then measure done latency and stall-high cycles
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int n;
      int st;
      @(negedge clk);
      funct3 = f; src1 = a; src2 = b; start = 1'b1;
      #1;
      chk({tag, " stall_req"}, 32'(stall), 32'd1);
      @(posedge clk);
      #1 start = 1'b0;
      n  = 0;
      st = 1;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (done) break;
         if (stall) st++;
      end
      chk({tag, " latency"}, 32'(n), 32'(exp_lat));
      chk({tag, " stall_cycles"}, 32'(st), 32'(exp_lat));
      chk({tag, " result"}, result, exp);
   endtask

   initial begin
      int pulses;

      #12;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset result", result, 32'd0);
      chk("reset stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("MUL",     3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op("MULHU",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("MULH",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_op("MULHSU",  3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
      run_op("DIV",     3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
      run_op("REM",     3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
      run_op("DIVU",    3'b101, 32'd100,      32'd7,        32'd14,        33);
      run_op("REMU",    3'b111, 32'd100,      32'd7,        32'd2,         33);
      run_op("DIVU_z",  3'b101, 32'h0000_1234, 32'd0,       32'hFFFF_FFFF, 1);
      run_op("DIV_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("REM_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
      run_op("REM_z",   3'b110, 32'h0000_1234, 32'd0,       32'h0000_1234, 1);

      // Flush in the middle of CALC
      @(negedge clk);
      funct3 = 3'b011; src1 = 32'd5; src2 = 32'd6; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush busy", 32'(busy), 32'd0);
      chk("flush stall", 32'(stall), 32'd0);
      chk("flush result", result, 32'h0000_1234);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) pulses++;
         @(negedge clk);
      end
      chk("flush no_done", 32'(pulses), 32'd0);
      run_op("MUL_after_flush", 3'b000, 32'd3, 32'd5, 32'd15, 33);

      // Asynchronous reset during CALC
      @(negedge clk);
      funct3 = 3'b101; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst busy", 32'(busy), 32'd0);
      chk("async_rst done", 32'(done), 32'd0);
      chk("async_rst result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Re-issue with start held high through CALC: exactly one done pulse
      @(negedge clk);
      funct3 = 3'b101; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            chk("held_start result", result, 32'd14);
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("held_start pulses", 32'(pulses), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
